// File: rtl/point_render_pipe.sv
// Pipelined point-cloud renderer: walks ZBT words 0..max_addr, rotates each point about Y,
// offsets it to screen space and streams samples through a credit-limited show-ahead FIFO.
// Optional screen clipping is enabled by defining POINT_RENDER_CLIP_EN.
module point_render_pipe #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int COORD_W      = 10,
    parameter int TRIG_W       = 8,
    parameter int TRIG_FRAC    = 6,
    parameter int OFF_W        = 11,
    parameter int OFF_SHIFT    = 3,
    parameter int SCREEN_W     = 11,
    parameter int DEPTH_BIAS   = 350,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        max_addr,
    input  logic [OFF_W-1:0]         x_offset,
    input  logic [OFF_W-1:0]         y_offset,
    input  logic signed [TRIG_W-1:0] sin_val,
    input  logic signed [TRIG_W-1:0] cos_val,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SCREEN_W-1:0]      out_x,
    output logic [SCREEN_W-1:0]      out_y,
    output logic [7:0]               out_pixel
);
    localparam int PROD_W = TRIG_W + COORD_W;
    localparam int SUM_W  = SCREEN_W + 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic signed [SUM_W-1:0] DEPTH_MAX = SUM_W'((1 << COORD_W) - 1);
    localparam logic signed [SUM_W-1:0] BIAS      = SUM_W'(DEPTH_BIAS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d, max_addr_q;
    logic [OFF_W-1:0]          xoff_q, yoff_q;
    logic signed [TRIG_W-1:0]  sin_q, cos_q;
    logic                      busy_q, busy_d, done_q, done_d;
    logic [READ_LATENCY-1:0]   vsr_q;
    logic [CNT_W-1:0]          inflight_q, count_q;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W:0]            credit_s;
    logic                      start_acc_s, issue_s, rd_v_s, keep_s, drop_s;
    logic                      clip_s, clip_drop_s, rd_en_s;

    logic signed [COORD_W-1:0] px_s, py_s, pz_s;
    logic signed [PROD_W-1:0]  cx_s, sz_s, sx_prod_s, cz_s;
    logic                      s1_v_q;
    logic signed [PROD_W-1:0]  s1_cx_q, s1_sz_q, s1_sx_q, s1_cz_q;
    logic signed [COORD_W-1:0] s1_y_q;
    logic signed [PROD_W:0]    xsum_s, zsum_s;
    logic signed [SUM_W-1:0]   xr_s, zr_s, sx_s, sy_s, depth_s;
    logic [SUM_W-1:0]          xoff_sh_s, yoff_sh_s;
    logic [COORD_W-1:0]        depth_sat_s;
    logic                      s2_v_q;
    logic [SCREEN_W-1:0]       s2_x_q, s2_y_q;
    logic [7:0]                s2_pix_q;
    logic [SCREEN_W-1:0]       fifo_x_q [FIFO_DEPTH];
    logic [SCREEN_W-1:0]       fifo_y_q [FIFO_DEPTH];
    logic [7:0]                fifo_p_q [FIFO_DEPTH];
    logic                      unused_s;

    // A read is only issued while every in-flight word is guaranteed a FIFO slot.
    assign credit_s    = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_s     = (state_q == S_ISSUE) && (credit_s < (CNT_W+1)'(FIFO_DEPTH));
    assign start_acc_s = (state_q == S_IDLE) && start;
    assign rd_v_s      = vsr_q[READ_LATENCY-1];
    assign keep_s      = rd_v_s && mem_data[DATA_W-1];
    assign drop_s      = rd_v_s && !mem_data[DATA_W-1];
    assign rd_en_s     = (count_q != {CNT_W{1'b0}}) && out_ready;

    // Frame sequencing: next state, read address, busy and done pulse.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    addr_d  = {ADDR_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (issue_s) begin
                    if (addr_q == max_addr_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1'b1);
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            S_DRAIN: begin
                if ((inflight_q == {CNT_W{1'b0}}) && (count_q == {CNT_W{1'b0}})) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control registers, per-frame parameter latch and read-tracking state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            max_addr_q <= {ADDR_W{1'b0}};
            xoff_q     <= {OFF_W{1'b0}};
            yoff_q     <= {OFF_W{1'b0}};
            sin_q      <= {TRIG_W{1'b0}};
            cos_q      <= {TRIG_W{1'b0}};
            vsr_q      <= {READ_LATENCY{1'b0}};
            inflight_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (start_acc_s) begin
                max_addr_q <= max_addr;
                xoff_q     <= x_offset;
                yoff_q     <= y_offset;
                sin_q      <= sin_val;
                cos_q      <= cos_val;
            end
            vsr_q      <= (vsr_q << 1) | READ_LATENCY'(issue_s);
            inflight_q <= inflight_q + CNT_W'(issue_s) - CNT_W'(drop_s)
                          - CNT_W'(clip_drop_s) - CNT_W'(s2_v_q);
        end
    end

    assign px_s      = mem_data[3*COORD_W-1 -: COORD_W];
    assign py_s      = mem_data[2*COORD_W-1 -: COORD_W];
    assign pz_s      = mem_data[COORD_W-1:0];
    assign cx_s      = PROD_W'(cos_q) * PROD_W'(px_s);
    assign sz_s      = PROD_W'(sin_q) * PROD_W'(pz_s);
    assign sx_prod_s = PROD_W'(sin_q) * PROD_W'(px_s);
    assign cz_s      = PROD_W'(cos_q) * PROD_W'(pz_s);

    assign xsum_s    = (PROD_W+1)'(s1_cx_q) + (PROD_W+1)'(s1_sz_q);
    assign zsum_s    = (PROD_W+1)'(s1_sx_q) - (PROD_W+1)'(s1_cz_q);
    assign xr_s      = SUM_W'(xsum_s >>> TRIG_FRAC);
    assign zr_s      = SUM_W'(zsum_s >>> TRIG_FRAC);
    assign xoff_sh_s = SUM_W'(xoff_q) << OFF_SHIFT;
    assign yoff_sh_s = SUM_W'(yoff_q) << OFF_SHIFT;
    assign sx_s      = xr_s + signed'(xoff_sh_s);
    assign sy_s      = SUM_W'(s1_y_q) + signed'(yoff_sh_s);
    assign depth_s   = zr_s + BIAS;

    // Depth clamps to the unsigned coordinate range before taking the intensity bits.
    always_comb begin
        depth_sat_s = {COORD_W{1'b0}};
        if (depth_s[SUM_W-1]) begin
            depth_sat_s = {COORD_W{1'b0}};
        end else if (depth_s > DEPTH_MAX) begin
            depth_sat_s = {COORD_W{1'b1}};
        end else begin
            depth_sat_s = depth_s[COORD_W-1:0];
        end
    end

`ifdef POINT_RENDER_CLIP_EN
    localparam logic signed [SUM_W-1:0] H_LIM = SUM_W'(H_ACTIVE);
    localparam logic signed [SUM_W-1:0] V_LIM = SUM_W'(V_ACTIVE);
    assign clip_s   = sx_s[SUM_W-1] || (sx_s >= H_LIM) || sy_s[SUM_W-1] || (sy_s >= V_LIM);
    assign unused_s = ^{mem_data[DATA_W-2:3*COORD_W], depth_sat_s[COORD_W-9:0]};
`else
    assign clip_s   = 1'b0;
    assign unused_s = ^{mem_data[DATA_W-2:3*COORD_W], depth_sat_s[COORD_W-9:0],
                        sx_s[SUM_W-1:SCREEN_W], sy_s[SUM_W-1:SCREEN_W],
                        1'(H_ACTIVE), 1'(V_ACTIVE)};
`endif
    assign clip_drop_s = s1_v_q && clip_s;

    // Two arithmetic stages: products, then rotation sums, offsets and depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s1_cx_q  <= {PROD_W{1'b0}};
            s1_sz_q  <= {PROD_W{1'b0}};
            s1_sx_q  <= {PROD_W{1'b0}};
            s1_cz_q  <= {PROD_W{1'b0}};
            s1_y_q   <= {COORD_W{1'b0}};
            s2_v_q   <= 1'b0;
            s2_x_q   <= {SCREEN_W{1'b0}};
            s2_y_q   <= {SCREEN_W{1'b0}};
            s2_pix_q <= 8'd0;
        end else begin
            s1_v_q   <= keep_s;
            s1_cx_q  <= cx_s;
            s1_sz_q  <= sz_s;
            s1_sx_q  <= sx_prod_s;
            s1_cz_q  <= cz_s;
            s1_y_q   <= py_s;
            s2_v_q   <= s1_v_q && !clip_s;
            s2_x_q   <= sx_s[SCREEN_W-1:0];
            s2_y_q   <= sy_s[SCREEN_W-1:0];
            s2_pix_q <= depth_sat_s[COORD_W-1 -: 8];
        end
    end

    // Show-ahead output FIFO; credits make a write into a full FIFO impossible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_x_q[i] <= {SCREEN_W{1'b0}};
                fifo_y_q[i] <= {SCREEN_W{1'b0}};
                fifo_p_q[i] <= 8'd0;
            end
        end else begin
            if (s2_v_q) begin
                fifo_x_q[wr_ptr_q] <= s2_x_q;
                fifo_y_q[wr_ptr_q] <= s2_y_q;
                fifo_p_q[wr_ptr_q] <= s2_pix_q;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
            end
            count_q <= count_q + CNT_W'(s2_v_q) - CNT_W'(rd_en_s);
        end
    end

    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign out_x     = fifo_x_q[rd_ptr_q];
    assign out_y     = fifo_y_q[rd_ptr_q];
    assign out_pixel = fifo_p_q[rd_ptr_q];
endmodule
